// File: rtl/axi_lite_slave_regs_if.sv
// rtl/axi_lite_slave_regs_if.sv - AXI4-Lite register bus bundle with master/slave views
interface axi_lite_slave_regs_if #(
  parameter int ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_slave_regs.sv
// rtl/axi_lite_slave_regs.sv - AXI4-Lite control/status register bank for the dot-product engine
module axi_lite_slave_regs #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  axi_lite_slave_regs_if.slave  s_axi,
  output logic                  start_o,
  output logic [31:0]           vector_a_addr_o,
  output logic [31:0]           vector_b_addr_o,
  output logic [31:0]           vector_len_o,
  output logic [31:0]           output_addr_o,
  input  logic                  busy_i,
  input  logic                  done_i,
  input  logic [31:0]           result_i
);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_ACC, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ACC, R_DATA} r_state_t;

  w_state_t    w_state_q, w_state_d;
  r_state_t    r_state_q, r_state_d;
  logic [1:0]  bresp_q, bresp_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [31:0] rdata_q, rdata_d;
  logic        start_q, start_d;
  logic        done_q, done_d;
  logic        clr_done;
  logic [31:0] result_q;
  logic [31:0] cfg_q [0:3];
  logic [31:0] cfg_d [0:3];
  logic [2:0]  w_idx, r_idx;
  logic        unused_addr_bits;

  assign w_idx = s_axi.awaddr[4:2];
  assign r_idx = s_axi.araddr[4:2];
  assign unused_addr_bits = ^{s_axi.awaddr[1:0], s_axi.awaddr[ADDR_WIDTH-1:5],
                              s_axi.araddr[1:0], s_axi.araddr[ADDR_WIDTH-1:5]};

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

  always_comb begin
    w_state_d = w_state_q;
    bresp_d   = bresp_q;
    start_d   = 1'b0;
    clr_done  = 1'b0;
    cfg_d     = cfg_q;
    case (w_state_q)
      W_IDLE: if (s_axi.awvalid && s_axi.wvalid) w_state_d = W_ACC;
      W_ACC: begin
        w_state_d = W_RESP;
        bresp_d   = RESP_OKAY;
        case (w_idx)
          3'd0: if (s_axi.wstrb[0] && s_axi.wdata[0]) begin
            if (busy_i) bresp_d = RESP_SLVERR;
            else        start_d = 1'b1;
          end
          3'd1: clr_done = s_axi.wstrb[0] && s_axi.wdata[1];
          3'd2, 3'd3, 3'd4, 3'd5: begin
            // Configuration is frozen while the engine is running.
            if (busy_i) bresp_d = RESP_SLVERR;
            else cfg_d[w_idx[1:0] - 2'd2] = merge_bytes(cfg_q[w_idx[1:0] - 2'd2],
                                                        s_axi.wdata, s_axi.wstrb);
          end
          default: bresp_d = RESP_SLVERR;
        endcase
      end
      W_RESP: if (s_axi.bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    done_d = done_q;
    if (done_i)                   done_d = 1'b1;
    else if (clr_done || start_d) done_d = 1'b0;
  end

  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: if (s_axi.arvalid) r_state_d = R_ACC;
      R_ACC: begin
        r_state_d = R_DATA;
        rresp_d   = RESP_OKAY;
        case (r_idx)
          3'd0:                   rdata_d = 32'h0;
          3'd1:                   rdata_d = {30'h0, done_q, busy_i};
          3'd2, 3'd3, 3'd4, 3'd5: rdata_d = cfg_q[r_idx[1:0] - 2'd2];
          3'd6:                   rdata_d = result_q;
          default: begin
            rdata_d = 32'h0;
            rresp_d = RESP_SLVERR;
          end
        endcase
      end
      R_DATA: if (s_axi.rready) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      bresp_q   <= RESP_OKAY;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= 32'h0;
      start_q   <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= 32'h0;
      for (int i = 0; i < 4; i++) cfg_q[i] <= 32'h0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      bresp_q   <= bresp_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      start_q   <= start_d;
      done_q    <= done_d;
      if (done_i) result_q <= result_i;
      cfg_q     <= cfg_d;
    end
  end

  assign s_axi.awready = (w_state_q == W_ACC);
  assign s_axi.wready  = (w_state_q == W_ACC);
  assign s_axi.bvalid  = (w_state_q == W_RESP);
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = (r_state_q == R_ACC);
  assign s_axi.rvalid  = (r_state_q == R_DATA);
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;

  assign start_o         = start_q;
  assign vector_a_addr_o = cfg_q[0];
  assign vector_b_addr_o = cfg_q[1];
  assign vector_len_o    = cfg_q[2];
  assign output_addr_o   = cfg_q[3];
endmodule

// File: doc/axi_lite_slave_regs.md
# axi_lite_slave_regs

AXI4-Lite responder and control/status register bank for the dot-product accelerator. It accepts register writes and reads from the accelerator's AXI-Lite master, drives the configuration and start pulse into the fetch/compute datapath, and captures the engine's result and completion status. The write and read channels run independent state machines.

## Interface
- `ADDR_WIDTH`, default 8: AXI address width in bits; bits [4:2] select the register; bits [1:0] and bits above [4] are ignored.
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: asynchronous, active-low reset.
- `awaddr` in ADDR_WIDTH, `awvalid` in 1, `awready` out 1: write address channel.
- `wdata` in 32, `wstrb` in 4, `wvalid` in 1, `wready` out 1: write data channel.
- `bresp` out 2, `bvalid` out 1, `bready` in 1: write response channel.
- `araddr` in ADDR_WIDTH, `arvalid` in 1, `arready` out 1: read address channel.
- `rdata` out 32, `rresp` out 2, `rvalid` out 1, `rready` in 1: read data channel.
- `start_o` out 1: one-cycle start pulse to the engine.
- `vector_a_addr_o`, `vector_b_addr_o`, `vector_len_o`, `output_addr_o` out 32 each: configuration registers, driven directly from the register flops.
- `busy_i` in 1: engine busy level.
- `done_i` in 1: one-cycle pulse when the engine completes.
- `result_i` in 32: engine result; valid in the cycle `done_i` is high.

## Operation
- Register map (byte offset):
  - 0x00 CTRL: write-only. A write with wstrb[0]=1 and wdata[0]=1 and busy_i=0 pulses `start_o`. The same write with busy_i=1 is dropped and returns SLVERR. Reads return 0.
  - 0x04 STATUS: bit0 = busy_i (live), bit1 = DONE (sticky). Writing 1 to bit1 with wstrb[0]=1 clears DONE (W1C). Other bits read 0.
  - 0x08 VEC_A_ADDR, 0x0C VEC_B_ADDR, 0x10 VEC_LEN, 0x14 OUT_ADDR: read/write with byte-lane writes per wstrb. A write while busy_i=1 leaves the register unchanged and returns SLVERR.
  - 0x18 RESULT: read-only. Loaded from result_i when done_i=1. A write returns SLVERR and changes nothing.
  - 0x1C: unmapped. Reads return 0 with SLVERR; writes return SLVERR.
- DONE update priority: done_i set > W1C clear. An accepted START also clears DONE in the same cycle, unless done_i is high in that cycle.
- Write FSM:
  - W_IDLE: when awvalid && wvalid, go to W_ACC. Address and data must arrive together; one without the other waits.
  - W_ACC: awready=wready=1 for exactly this cycle. The register update, start_o and bresp are decided from awaddr/wdata/wstrb sampled in this cycle. Next state is W_RESP.
  - W_RESP: bvalid=1, bresp held stable; on bready go to W_IDLE.
- Read FSM:
  - R_IDLE: when arvalid, go to R_ACC.
  - R_ACC: arready=1 for one cycle; rdata and rresp are registered at the end of this cycle from the current register contents. Next state is R_DATA.
  - R_DATA: rvalid=1, rdata and rresp held stable; on rready go to R_IDLE.
- Response codes: OKAY=2'b00, SLVERR=2'b10.

## Timing
- Reset (asynchronous, rst=0): both FSMs go to IDLE; awready, wready, arready, bvalid, rvalid, start_o = 0; bresp, rresp = 2'b00; rdata = 0; all configuration registers, RESULT and DONE = 0.
- Write latency, with awvalid&&wvalid first sampled at edge N:
  - awready/wready high in cycle N+1.
  - Register update, and start_o high for one cycle, in cycle N+2.
  - bvalid high from cycle N+2 until bready is sampled.
- Read latency, with arvalid first sampled at edge N: arready high in cycle N+1; rvalid high from cycle N+2 until rready is sampled.
- Back-to-back transactions: at most one outstanding transaction per channel. A new write is not accepted while bvalid=1; a new read is not accepted while rvalid=1. Minimum period is 3 cycles per transaction with bready/rready held high.
- Write and read to the same register in the same W_ACC/R_ACC cycle: the read returns the pre-write value.
- done_i and a RESULT read in the same R_ACC cycle: the read returns the old RESULT.
- Reset mid-transaction: the transaction is abandoned with no response, and any pending start_o is suppressed.

## Test plan
- After reset, read 0x08..0x18 -> each read returns 0x0000_0000 with OKAY.
- Write 0x08 = 0x1000_0000 with wstrb=4'hF, then write 0x08 = 0xAB with wstrb=4'h1 -> a read of 0x08 returns 0x1000_00AB; awready/wready are high exactly 1 cycle; bvalid is high 2 cycles after valid is first sampled.
- With busy_i=0, write CTRL = 1 -> start_o is high for exactly 1 cycle with OKAY. Raise busy_i, then write CTRL = 1 and write 0x10 = 5 -> both return SLVERR, start_o stays 0, and VEC_LEN is unchanged.
- Pulse done_i with result_i = 0x0000_0037 -> STATUS reads 0x2 and RESULT reads 0x37. Write STATUS = 0x2 -> STATUS reads 0x0. Pulse done_i in the same cycle as a W1C write -> STATUS reads 0x2.
- Read 0x1C and write 0x18 -> SLVERR on both, rdata = 0, RESULT unchanged.
- Hold bready=0 for 5 cycles after a write -> bvalid and bresp stay stable, and a second awvalid/wvalid gets no awready until 1 cycle after bready is sampled. Assert rst mid-W_RESP -> bvalid drops asynchronously to 0.
